joystick_move_ctrl: RTL and testbench

- Consumes raw 10-bit joystick X/Y positions from the PmodJSTK SPI front end.
- Classifies each sample into a direction code, debounces it, and holds it as a pending turn request.
- Issues Pac-Man movement steps at a fixed rate, honouring wall-blocking from the maze logic.
- Sits between the joystick interface and the sprite position/maze update logic.

---
 rtl/joystick_move_ctrl_if.sv | 22 ++
 rtl/joystick_move_ctrl.sv | 104 ++++++++++
 tb/tb_joystick_move_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/joystick_move_ctrl_if.sv
// Joystick sample / maze-block inputs and movement outputs.
// master drives samples and walls; slave is the move controller.
interface joystick_move_ctrl_if;
  logic       sample_valid;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] blocked;
  logic [2:0] dir;
  logic [2:0] req_dir;
  logic       move_tick;
  logic       stopped;

  modport master (
    output sample_valid, pos_x, pos_y, blocked,
    input  dir, req_dir, move_tick, stopped
  );

  modport slave (
    input  sample_valid, pos_x, pos_y, blocked,
    output dir, req_dir, move_tick, stopped
  );
endinterface

// File: rtl/joystick_move_ctrl.sv
// Joystick -> debounced direction request -> fixed-rate Pac-Man steps.
// Ports: CLK, RST (sync, active-high), bus (slave: samples, walls, dir/req/tick/stopped).
module joystick_move_ctrl #(
  parameter int HI_TH    = 800,
  parameter int LO_TH    = 200,
  parameter int STABLE_N = 3,
  parameter int MOVE_DIV = 10000000
) (
  input logic CLK,
  input logic RST,
  joystick_move_ctrl_if.slave bus
);
  localparam int CW  = $clog2(STABLE_N + 1);
  localparam int TW  = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_N);
  localparam logic [TW-1:0] CTR_MAX = TW'(MOVE_DIV - 1);

  logic [2:0]    cls;
  logic [2:0]    cand_q, cand_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    req_q;
  logic [2:0]    dir_q, nd;
  logic [TW-1:0] ctr_q;
  logic          tick_q, stop_q;
  logic          step;
  logic          req_ok, nd_free;

  function automatic logic is_free(
    input logic [2:0] d,
    input logic [3:0] blk
  );
    logic f;
    f = 1'b0;
    case (d)
      3'd1:    f = ~blk[0];
      3'd2:    f = ~blk[1];
      3'd3:    f = ~blk[2];
      3'd4:    f = ~blk[3];
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Y axis is tested first so diagonals resolve vertically.
  always_comb begin
    cls = 3'd0;
    if (32'(bus.pos_y) > HI_TH)      cls = 3'd1;
    else if (32'(bus.pos_y) < LO_TH) cls = 3'd2;
    else if (32'(bus.pos_x) > HI_TH) cls = 3'd3;
    else if (32'(bus.pos_x) < LO_TH) cls = 3'd4;
  end

  always_comb begin
    cand_n = cls;
    cnt_n  = CW'(1);
    if (cls == cand_q) begin
      cand_n = cand_q;
      cnt_n  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Step decision uses pre-edge req/dir/blocked.
  always_comb begin
    step    = (ctr_q == CTR_MAX);
    req_ok  = is_free(req_q, bus.blocked);
    nd      = req_ok ? req_q : dir_q;
    nd_free = is_free(nd, bus.blocked);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cand_q <= 3'd0;
      cnt_q  <= '0;
      req_q  <= 3'd0;
    end else if (bus.sample_valid) begin
      cand_q <= cand_n;
      cnt_q  <= cnt_n;
      // Centred stick never clears a pending request.
      if (cnt_n == CNT_MAX && cand_n != 3'd0)
        req_q <= cand_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctr_q  <= '0;
      dir_q  <= 3'd0;
      tick_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      ctr_q  <= step ? '0 : ctr_q + TW'(1);
      tick_q <= step & nd_free;
      if (step) begin
        dir_q  <= nd;
        stop_q <= (nd != 3'd0) & ~nd_free;
      end
    end
  end

  assign bus.dir       = dir_q;
  assign bus.req_dir   = req_q;
  assign bus.move_tick = tick_q;
  assign bus.stopped   = stop_q;
endmodule

// File: tb/tb_joystick_move_ctrl.sv
// Directed bench for joystick_move_ctrl.
// Table of samples plus stepping / wall sequences.
module tb_joystick_move_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;

  joystick_move_ctrl_if bus ();

  joystick_move_ctrl #(
    .HI_TH(800), .LO_TH(200), .STABLE_N(3), .MOVE_DIV(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x;
    int y;
    int req;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int x, input int y);
    @(negedge CLK);
    bus.sample_valid = 1'b1;
    bus.pos_x = 10'(x);
    bus.pos_y = 10'(y);
    @(negedge CLK);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.move_tick !== 1'b1 && n < 40);
    if (bus.move_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick in %0d cycles want tick", n);
    end
  endtask

  initial begin
    int n;
    int hi;
    tbl[0]  = '{512, 900, 0};
    tbl[1]  = '{512, 900, 0};
    tbl[2]  = '{512, 900, 1};
    tbl[3]  = '{1000, 100, 1};
    tbl[4]  = '{512, 512, 1};
    tbl[5]  = '{1000, 100, 1};
    tbl[6]  = '{1000, 100, 1};
    tbl[7]  = '{1000, 100, 2};
    tbl[8]  = '{200, 800, 2};
    tbl[9]  = '{200, 800, 2};
    tbl[10] = '{200, 800, 2};
    tbl[11] = '{801, 512, 2};
    tbl[12] = '{801, 512, 2};
    tbl[13] = '{801, 512, 3};
    tbl[14] = '{199, 512, 3};
    tbl[15] = '{199, 512, 3};
    tbl[16] = '{199, 512, 4};
    tbl[17] = '{800, 801, 4};
    tbl[18] = '{800, 801, 4};
    tbl[19] = '{800, 801, 1};
    tbl[20] = '{800, 801, 1};
    tbl[21] = '{801, 200, 1};
    tbl[22] = '{801, 200, 1};
    tbl[23] = '{801, 200, 3};

    bus.sample_valid = 1'b1;
    bus.pos_x = 10'd512;
    bus.pos_y = 10'd1000;
    bus.blocked = 4'hF;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_dir", int'(bus.dir), 0);
      chk("rst_req", int'(bus.req_dir), 0);
      chk("rst_tick", int'(bus.move_tick), 0);
      chk("rst_stop", int'(bus.stopped), 0);
    end
    bus.sample_valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_req", int'(bus.req_dir), 0);
    chk("rel_dir", int'(bus.dir), 0);

    // All walls up: dir stays 0 while requests are exercised.
    for (int i = 0; i < 24; i++) begin
      sample(tbl[i].x, tbl[i].y);
      chk($sformatf("vec%0d_req", i), int'(bus.req_dir), tbl[i].req);
      chk($sformatf("vec%0d_dir", i), int'(bus.dir), 0);
      chk($sformatf("vec%0d_stop", i), int'(bus.stopped), 0);
    end

    bus.blocked = 4'h0;
    wait_tick(n);
    chk("go_dir", int'(bus.dir), 3);
    chk("go_stop", int'(bus.stopped), 0);
    wait_tick(n);
    chk("period", n, 8);
    @(negedge CLK);
    chk("tick_width", int'(bus.move_tick), 0);

    for (int i = 0; i < 3; i++) sample(512, 512);
    wait_tick(n);
    chk("centre_dir", int'(bus.dir), 3);
    chk("centre_req", int'(bus.req_dir), 3);

    bus.blocked = 4'b0001;
    for (int i = 0; i < 3; i++) sample(512, 900);
    chk("pre_req", int'(bus.req_dir), 1);
    wait_tick(n);
    chk("pre_hold_dir", int'(bus.dir), 3);
    bus.blocked = 4'b0100;
    wait_tick(n);
    chk("turn_dir", int'(bus.dir), 1);
    chk("turn_tick", int'(bus.move_tick), 1);

    bus.blocked = 4'b0000;
    for (int i = 0; i < 3; i++) sample(900, 512);
    wait_tick(n);
    wait_tick(n);
    chk("dead_dir0", int'(bus.dir), 3);
    bus.blocked = 4'b0100;
    hi = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      if (bus.move_tick) hi++;
    end
    chk("dead_ticks", hi, 0);
    chk("dead_stop", int'(bus.stopped), 1);
    chk("dead_dir", int'(bus.dir), 3);
    bus.blocked = 4'b0000;
    wait_tick(n);
    chk("resume_wait_le8", int'(n <= 8), 1);
    chk("resume_stop", int'(bus.stopped), 0);

    // Reset mid-step: no tick afterwards, everything cleared.
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_dir", int'(bus.dir), 0);
    chk("mid_rst_req", int'(bus.req_dir), 0);
    hi = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      if (bus.move_tick) hi++;
    end
    chk("mid_rst_ticks", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
